// File: rtl/pipe_trace_tag.sv
// Instruction-tag tracker for the trace logger: allocates serial IDs at fetch and
// follows them through I, X, M and R, reporting stage entries, wrong-path kills and counts.
module pipe_trace_tag #(
  parameter int              ID_W     = 32,
  parameter logic [ID_W-1:0] RESET_ID = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic            stall_x,
  input  logic            flush_x,
  output logic            inst_v_i,
  output logic [ID_W-1:0] ci,
  output logic            inst_v_x,
  output logic [ID_W-1:0] cx,
  output logic            inst_v_m,
  output logic [ID_W-1:0] cm,
  output logic            inst_v_r,
  output logic [ID_W-1:0] cr,
  output logic            inst_v_k,
  output logic [ID_W-1:0] ck,
  output logic [ID_W-1:0] retired_cnt,
  output logic [ID_W-1:0] killed_cnt
);

  localparam logic [ID_W-1:0] ONE = {{(ID_W-1){1'b0}}, 1'b1};

  function automatic logic [ID_W-1:0] inc_wrap(input logic [ID_W-1:0] a);
    return a + ONE;
  endfunction

  logic            v_i_q, v_i_d, e_i_q, e_i_d;
  logic            v_x_q, v_x_d, e_x_q, e_x_d;
  logic            v_m_q, v_m_d, v_r_q, v_r_d, v_k_q, v_k_d;
  logic [ID_W-1:0] id_i_q, id_i_d, id_x_q, id_x_d, id_m_q, id_m_d;
  logic [ID_W-1:0] id_r_q, id_r_d, id_k_q, id_k_d;
  logic [ID_W-1:0] next_id_q, next_id_d;
  logic [ID_W-1:0] ret_cnt_q, ret_cnt_d, kill_cnt_q, kill_cnt_d;
  logic            fl, acc;

  assign if_ready = !v_i_q || !stall_x;

  always_comb begin
    fl         = flush_x && v_x_q && !stall_x;
    acc        = if_valid && if_ready && !fl;
    v_i_d      = v_i_q;
    id_i_d     = id_i_q;
    e_i_d      = 1'b0;
    v_x_d      = v_x_q;
    id_x_d     = id_x_q;
    e_x_d      = 1'b0;
    v_m_d      = 1'b0;
    id_m_d     = id_m_q;
    v_r_d      = v_m_q;
    id_r_d     = id_m_q;
    v_k_d      = 1'b0;
    id_k_d     = id_k_q;
    next_id_d  = next_id_q;
    ret_cnt_d  = ret_cnt_q + {{(ID_W-1){1'b0}}, v_r_q};
    kill_cnt_d = kill_cnt_q;

    // I -> X -> M advance together; a stall holds I and X and injects a bubble into M
    if (!stall_x) begin
      v_m_d = v_x_q;
      if (v_x_q) id_m_d = id_x_q;
      v_x_d = v_i_q && !fl;
      if (v_i_q && !fl) begin
        id_x_d = id_i_q;
        e_x_d  = 1'b1;
      end
      v_i_d = 1'b0;
    end

    // the instruction behind a taken branch in X is wrong-path
    if (fl && v_i_q) begin
      v_k_d      = 1'b1;
      id_k_d     = id_i_q;
      kill_cnt_d = inc_wrap(kill_cnt_q);
    end

    if (acc) begin
      v_i_d     = 1'b1;
      id_i_d    = next_id_q;
      e_i_d     = 1'b1;
      next_id_d = inc_wrap(next_id_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_i_q      <= 1'b0;
      e_i_q      <= 1'b0;
      v_x_q      <= 1'b0;
      e_x_q      <= 1'b0;
      v_m_q      <= 1'b0;
      v_r_q      <= 1'b0;
      v_k_q      <= 1'b0;
      id_i_q     <= RESET_ID;
      id_x_q     <= RESET_ID;
      id_m_q     <= RESET_ID;
      id_r_q     <= RESET_ID;
      id_k_q     <= RESET_ID;
      next_id_q  <= RESET_ID;
      ret_cnt_q  <= '0;
      kill_cnt_q <= '0;
    end else begin
      v_i_q      <= v_i_d;
      e_i_q      <= e_i_d;
      v_x_q      <= v_x_d;
      e_x_q      <= e_x_d;
      v_m_q      <= v_m_d;
      v_r_q      <= v_r_d;
      v_k_q      <= v_k_d;
      id_i_q     <= id_i_d;
      id_x_q     <= id_x_d;
      id_m_q     <= id_m_d;
      id_r_q     <= id_r_d;
      id_k_q     <= id_k_d;
      next_id_q  <= next_id_d;
      ret_cnt_q  <= ret_cnt_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign inst_v_i    = v_i_q && e_i_q;
  assign inst_v_x    = v_x_q && e_x_q;
  assign inst_v_m    = v_m_q;
  assign inst_v_r    = v_r_q;
  assign inst_v_k    = v_k_q;
  assign ci          = id_i_q;
  assign cx          = id_x_q;
  assign cm          = id_m_q;
  assign cr          = id_r_q;
  assign ck          = id_k_q;
  assign retired_cnt = ret_cnt_q;
  assign killed_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_trace_tag.sv
// Scoreboard bench for pipe_trace_tag: a transaction-level model predicts every stage
// event (ID and cycle); a negedge monitor pops and compares whenever a strobe appears.
module tb_pipe_trace_tag;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, if_valid, stall_x, flush_x, if_ready;
  logic        inst_v_i, inst_v_x, inst_v_m, inst_v_r, inst_v_k;
  logic [31:0] ci, cx, cm, cr, ck, retired_cnt, killed_cnt;

  logic        reset2, if_valid2, if_ready2;
  logic        v_i2, v_x2, v_m2, v_r2, v_k2;
  logic [31:0] ci2, cx2, cm2, cr2, ck2, rc2, kc2;

  pipe_trace_tag #(.ID_W(32), .RESET_ID(32'h0)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .stall_x(stall_x), .flush_x(flush_x),
    .inst_v_i(inst_v_i), .ci(ci), .inst_v_x(inst_v_x), .cx(cx),
    .inst_v_m(inst_v_m), .cm(cm), .inst_v_r(inst_v_r), .cr(cr),
    .inst_v_k(inst_v_k), .ck(ck), .retired_cnt(retired_cnt), .killed_cnt(killed_cnt));

  pipe_trace_tag #(.ID_W(32), .RESET_ID(32'hFFFF_FFFE)) dut2 (
    .clk(clk), .reset(reset2), .if_valid(if_valid2), .if_ready(if_ready2),
    .stall_x(1'b0), .flush_x(1'b0),
    .inst_v_i(v_i2), .ci(ci2), .inst_v_x(v_x2), .cx(cx2),
    .inst_v_m(v_m2), .cm(cm2), .inst_v_r(v_r2), .cr(cr2),
    .inst_v_k(v_k2), .ck(ck2), .retired_cnt(rc2), .killed_cnt(kc2));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] id;
    int          cyc;
    logic [31:0] cnt;
  } ev_t;

  // event queues: 0=I 1=X 2=M 3=R 4=K
  ev_t q [5][$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input logic [31:0] id, input int c, input logic [31:0] cnt);
    ev_t e;
    e.id = id; e.cyc = c; e.cnt = cnt;
    q[p].push_back(e);
  endtask

  // reference model: which ID sits in I and in X, and the allocation/event counts
  bit          m_init = 0;
  bit          m_iv, m_xv;
  logic [31:0] m_i, m_x, m_nid, m_rc, m_kc;

  function automatic bit model_ready(input bit st);
    return !m_iv || !st;
  endfunction

  task automatic model_step(input bit rs, input bit iv, input bit st, input bit fv);
    int  e;
    bit  fl, acc;
    e = cyc + 1;
    if (rs) begin
      for (int p = 0; p < 5; p++)
        while (q[p].size() > 0 && q[p][q[p].size()-1].cyc > cyc) void'(q[p].pop_back());
      m_iv = 0; m_xv = 0; m_nid = 32'h0; m_rc = 0; m_kc = 0; m_init = 1;
      return;
    end
    fl  = fv && m_xv && !st;
    acc = iv && model_ready(st) && !fl;
    if (!st) begin
      if (m_xv) begin
        push(2, m_x, e, 0);
        push(3, m_x, e + 1, 0);
        m_rc = m_rc + 1;
      end
      m_xv = 0;
      if (m_iv) begin
        if (fl) begin
          m_kc = m_kc + 1;
          push(4, m_i, e, m_kc);
        end else begin
          push(1, m_i, e, 0);
          m_xv = 1; m_x = m_i;
        end
      end
      m_iv = 0;
    end
    if (acc) begin
      push(0, m_nid, e, 0);
      m_iv = 1; m_i = m_nid;
      m_nid = m_nid + 32'd1;
    end
  endtask

  task automatic step(input bit rs, input bit iv, input bit st, input bit fv);
    reset = rs; if_valid = iv; stall_x = st; flush_x = fv;
    #1;
    if (m_init) check("if_ready", {31'b0, if_ready}, {31'b0, model_ready(st)});
    model_step(rs, iv, st, fv);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_and_check(input int n);
    repeat (n) step(0, 0, 0, 0);
    for (int p = 0; p < 5; p++) check($sformatf("pending_q%0d", p), q[p].size(), 0);
    check("retired_cnt", retired_cnt, m_rc);
    check("killed_cnt", killed_cnt, m_kc);
  endtask

  logic [4:0]  stb;
  logic [31:0] ids [5];
  assign stb = {inst_v_k, inst_v_r, inst_v_m, inst_v_x, inst_v_i};
  assign ids[0] = ci;
  assign ids[1] = cx;
  assign ids[2] = cm;
  assign ids[3] = cr;
  assign ids[4] = ck;

  always @(negedge clk) begin
    ev_t ev;
    if (m_init) begin
      for (int p = 0; p < 5; p++) begin
        while (q[p].size() > 0 && q[p][0].cyc < cyc) begin
          ev = q[p].pop_front();
          tests++; fails++;
          $display("FAIL missing_strobe_q%0d: id %h never appeared, required at cycle %0d", p, ev.id, ev.cyc);
        end
        if (stb[p]) begin
          if (q[p].size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_strobe_q%0d: got id %h at cycle %0d, required none", p, ids[p], cyc);
          end else begin
            ev = q[p].pop_front();
            check($sformatf("id_q%0d", p), ids[p], ev.id);
            check($sformatf("cycle_q%0d", p), cyc, ev.cyc);
            if (p == 4) check("killed_cnt_at_kill", killed_cnt, ev.cnt);
          end
        end
      end
    end
  end

  logic [31:0] exp2 [3];
  int          k2;

  initial begin
    reset2 = 1'b1; if_valid2 = 1'b0;
    exp2[0] = 32'hFFFF_FFFE; exp2[1] = 32'hFFFF_FFFF; exp2[2] = 32'h0000_0000;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_strobes", {27'b0, stb}, 32'h0);
    check("rst_retired", retired_cnt, 32'h0);
    check("rst_killed", killed_cnt, 32'h0);

    // four back-to-back fetches
    repeat (4) step(0, 1, 0, 0);
    drain_and_check(8);
    check("retired_after_4", retired_cnt, 32'd4);

    // IDs 4,5,6 then a 3-cycle stall with 5 in X and 6 in I
    repeat (3) step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0);
      check("stall_ready", {31'b0, if_ready}, 32'h0);
      check("stall_ci", ci, 32'd6);
      check("stall_cx", cx, 32'd5);
      check("stall_bubble", {29'b0, inst_v_i, inst_v_x, inst_v_m}, 32'h0);
    end
    drain_and_check(8);

    // flush with 7 in X, 8 in I and a fetch offered in the same cycle
    repeat (2) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    check("flush_vk", {31'b0, inst_v_k}, 32'h1);
    check("flush_ck", ck, 32'd8);
    check("flush_kcnt", killed_cnt, 32'd1);
    step(0, 1, 0, 0);
    check("after_flush_ci", ci, 32'd9);
    drain_and_check(8);

    // flush during stall is ignored, then honoured once released
    repeat (2) step(0, 1, 0, 0);
    repeat (2) begin
      step(0, 0, 1, 1);
      check("stalled_flush_vk", {31'b0, inst_v_k}, 32'h0);
    end
    step(0, 0, 0, 1);
    check("late_flush_ck", ck, 32'd11);
    check("late_flush_kcnt", killed_cnt, 32'd2);
    drain_and_check(8);

    // reset with four instructions in flight
    repeat (4) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("midrst_retired", retired_cnt, 32'h0);
    check("midrst_killed", killed_cnt, 32'h0);
    step(0, 1, 0, 0);
    check("midrst_first_ci", ci, 32'h0);
    drain_and_check(8);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20);
    drain_and_check(10);

    // second instance: ID wrap from RESET_ID = 2^32-2
    reset2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_valid2 = 1'b1;
      step(0, 0, 0, 0);
      check("wrap_vi", {31'b0, v_i2}, 32'h1);
      check("wrap_ci", ci2, exp2[i]);
    end
    if_valid2 = 1'b0;
    k2 = 0;
    for (int i = 0; i < 8; i++) begin
      if (v_r2) begin
        if (k2 < 3) check("wrap_cr", cr2, exp2[k2]);
        else check("wrap_extra_retire", cr2, 32'hDEAD_BEEF);
        k2++;
      end
      step(0, 0, 0, 0);
    end
    check("wrap_retire_count", k2, 3);
    check("wrap_retired_cnt", rc2, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_trace_tag.md
Name: pipe_trace_tag

Overview:
- Pipeline instruction-tag tracker that sits directly upstream of the simulation trace/Konata logger.
- Allocates a serial ID to every fetched instruction and follows it through the I, X, M and R stages.
- Drives per-stage entry strobes and IDs: inst_v_i/x/m/r with ci/cx/cm/cr.
- Also reports wrong-path kills and keeps retire/kill counters.

Parameters:
- ID_W, 32, width of instruction IDs and counters.
- RESET_ID, 0, first ID allocated after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents an instruction this cycle
- if_ready  out  1  tracker accepts fetch: !v_i || !stall_x
- stall_x  in  1  X stage holds its instruction; I also holds
- flush_x  in  1  instruction in X is a taken branch/jump; younger instructions are wrong-path
- inst_v_i  out  1  strobe: instruction entered I this cycle
- ci  out  ID_W  ID in I
- inst_v_x  out  1  strobe: instruction entered X
- cx  out  ID_W  ID in X
- inst_v_m  out  1  strobe: instruction entered M
- cm  out  ID_W  ID in M
- inst_v_r  out  1  strobe: instruction retired (R stage)
- cr  out  ID_W  ID in R
- inst_v_k  out  1  strobe: instruction killed from I
- ck  out  ID_W  killed ID
- retired_cnt  out  ID_W  total retired since reset
- killed_cnt  out  ID_W  total killed since reset

Behaviour:
- State: v_i/id_i, v_x/id_x, v_m/id_m, v_r/id_r, next_id, entry flags e_i and e_x, counters.
- Reset: on clk rising edge with reset=1, all valids, entry flags and strobes go to 0; all IDs and next_id go to RESET_ID; counters go to 0.
- Reset mid-operation discards in-flight instructions. No R or K events are emitted for them.
- Effective flush: fl = flush_x && v_x && !stall_x. flush_x is ignored while stall_x=1 or while X is empty.
- Fetch acceptance: acc = if_valid && if_ready && !fl.
  - On acc: v_i<=1, id_i<=next_id, next_id<=next_id+1 (wraps at 2^ID_W), e_i<=1.
  - A fetch presented in a flush cycle is dropped and consumes no ID.
- I to X: when !stall_x and v_i and !fl, X gets id_i and e_x<=1.
  - If I advances with no new acc, v_i<=0.
  - If stall_x=1, I and X hold, e_i<=0 and e_x<=0, so each strobe lasts exactly one cycle.
- Kill: when fl && v_i, I is invalidated.
  - Next cycle: inst_v_k=1, ck=killed ID, killed_cnt+1.
- X to M: when !stall_x and v_x, M gets id_x. When stall_x=1, M receives a bubble. M never stalls.
- M to R: R always gets M contents the next cycle (v_r<=v_m, id_r<=id_m). R holds each instruction for one cycle.
- Strobe decode:
  - inst_v_i=v_i&&e_i
  - inst_v_x=v_x&&e_x
  - inst_v_m=v_m
  - inst_v_r=v_r
- retired_cnt increments in every cycle where v_r=1.
- Output latency:
  - Accepted fetch at edge n: inst_v_i is asserted in cycle n+1.
  - Unstalled: X at n+2, M at n+3, R at n+4.
- ID outputs (ci, cx, cm, cr, ck) hold their last value when the matching valid is 0. Consumers qualify IDs with the strobes only.
- Simultaneous events:
  - A kill and a retire in the same cycle are both reported, on separate ports.
  - A fetch into an empty I during stall_x is accepted, since if_ready=1.
- Counter wrap: next_id, retired_cnt and killed_cnt wrap modulo 2^ID_W with no saturation.
- Invariants (bench assertions):
  - IDs in R are strictly increasing, ignoring wrap.
  - Every allocated ID is reported exactly once, via either R or K.
  - if_ready=0 only when v_i=1 and stall_x=1.

Test Plan:
- Reset, then if_valid=1 for 4 cycles with no stall.
  - Expect inst_v_i for IDs 0,1,2,3 in consecutive cycles.
  - ID 0 reaches X at +1, M at +2, R at +3 relative to its I strobe.
  - retired_cnt=4 after the drain.
- stall_x=1 for 3 cycles with ID 5 in X and ID 6 in I.
  - if_ready=0 and ci/cx hold at 6/5.
  - inst_v_i and inst_v_x do not re-pulse.
  - M shows 3 bubble cycles.
  - After release, 5 and then 6 each enter M exactly once.
- flush_x=1 with ID 7 in X, ID 8 in I, and if_valid=1 in the same cycle.
  - Next cycle: inst_v_k=1, ck=8, killed_cnt=1.
  - The fetched instruction gets no ID; the next accepted fetch gets ID 9.
  - ID 7 retires normally.
- flush_x=1 while stall_x=1: no kill, and no state change beyond the stall. Assert flush_x again once the stall is released, and the kill then occurs.
- Assert reset with 4 instructions in flight.
  - No R or K strobes are emitted during or after reset.
  - The next fetch gets RESET_ID=0 and the counters read 0.
- RESET_ID=2^32-2: three accepted fetches get IDs 0xFFFFFFFE, 0xFFFFFFFF and 0x00000000, and all three retire in order.
